// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: I/D-cache read arbiter onto one AXI read port; define ARB_RR_EN for round-robin ties
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        rd_err
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_nx;
  logic owner;
  logic pick_d;
  logic take;
  assign take = (state == IDLE) & (i_arvalid | d_arvalid);
  assign m_arid = owner ? DATA_ID : INST_ID;
  assign m_arburst = 2'b01;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
`ifdef ARB_RR_EN
  logic last_grant;
  assign pick_d = d_arvalid & (~i_arvalid | ~last_grant);
  // remember which master won the most recent grant
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b0;
    else if (take) last_grant <= pick_d;
`else
  assign pick_d = d_arvalid;
`endif
  // state register, request capture and sticky response error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      m_araddr <= '0;
      m_arlen <= '0;
      m_arsize <= '0;
      rd_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        owner <= pick_d;
        m_araddr <= pick_d ? d_araddr : i_araddr;
        m_arlen <= pick_d ? d_arlen : i_arlen;
        m_arsize <= pick_d ? d_arsize : i_arsize;
      end
      if (state == R && m_rvalid && m_rready && m_rresp != 2'b00) rd_err <= 1'b1;
    end
  end
  // next state, grant pulses and beat routing to the owner
  always_comb begin
    state_nx = state;
    i_arready = 1'b0;
    d_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rlast = 1'b0;
    d_rlast = 1'b0;
    case (state)
      IDLE: begin
        i_arready = i_arvalid & ~pick_d;
        d_arready = pick_d;
        state_nx = take ? AR : IDLE;
      end
      AR: begin
        m_arvalid = 1'b1;
        state_nx = m_arready ? R : AR;
      end
      R: begin
        m_rready = owner ? d_rready : i_rready;
        i_rvalid = ~owner & m_rvalid;
        d_rvalid = owner & m_rvalid;
        i_rlast = ~owner & m_rlast;
        d_rlast = owner & m_rlast;
        state_nx = (m_rvalid & m_rready & m_rlast) ? IDLE : R;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for the I/D read arbiter
module tb_axi_rd_arbiter;
  logic clk = 0, rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, m_araddr, m_rdata;
  logic [7:0] i_arlen, d_arlen, m_arlen;
  logic [2:0] i_arsize, d_arsize, m_arsize;
  logic i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic [3:0] m_arid;
  logic [1:0] m_arburst, m_rresp;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, rd_err;
  int errors = 0, checks = 0;
  logic [33:0] q[$];
  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready), .rd_err(rd_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pat(input logic [31:0] base, input int k);
    return (base + 32'(k) * 32'd4) ^ 32'h5A5A_0000;
  endfunction
  // every cache-side handshake must match the next expected beat
  always @(negedge clk) if (!rst) begin
    if (i_rvalid && d_rvalid) begin
      checks++; errors++;
      $display("FAIL both_rvalid got=11 exp=one-hot");
    end
    if ((i_rvalid && i_rready) || (d_rvalid && d_rready)) begin
      logic [33:0] got, exp;
      got = {d_rvalid, d_rvalid ? d_rlast : i_rlast, d_rvalid ? d_rdata : i_rdata};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got=%h exp=none", got);
      end else begin
        exp = q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat got=%h exp=%h", got, exp);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ar;
    bit done = 0;
    m_arready = 1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = m_arvalid;
      tick;
    end
    m_arready = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL ar_timeout got=0 exp=1");
    end
  endtask
  task automatic beat(input bit side, input logic [31:0] data, input bit last, input logic [1:0] resp);
    bit done = 0;
    m_rvalid = 1; m_rdata = data; m_rlast = last; m_rresp = resp;
    q.push_back({side, last, data});
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = m_rready;
      tick;
    end
    m_rvalid = 0; m_rlast = 0; m_rresp = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL beat_timeout got=0 exp=1");
    end
  endtask
  task automatic burst(input bit side, input logic [31:0] base, input int n);
    wait_ar;
    for (int k = 0; k < n; k++) beat(side, pat(base, k), k == n - 1, 2'b00);
  endtask
  task automatic test_reset;
    checks++;
    if ({m_arvalid, m_rready, rd_err, i_arready, d_arready, i_rvalid, d_rvalid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=0000000", {m_arvalid, m_rready, rd_err, i_arready, d_arready, i_rvalid, d_rvalid});
    end
    checks++;
    if ({m_arid, m_araddr, m_arlen, m_arsize} !== 47'b0) begin
      errors++;
      $display("FAIL reset_regs got=%h exp=0", {m_arid, m_araddr, m_arlen, m_arsize});
    end
    checks++;
    if (m_arburst !== 2'b01) begin
      errors++;
      $display("FAIL reset_burst got=%b exp=01", m_arburst);
    end
  endtask
  task automatic test_i_only;
    i_araddr = 32'h1FC0_0020; i_arlen = 7; i_arsize = 2; i_arvalid = 1;
    @(negedge clk);
    checks++;
    if ({i_arready, d_arready} !== 2'b10) begin
      errors++;
      $display("FAIL i_grant got=%b exp=10", {i_arready, d_arready});
    end
    tick;
    i_arvalid = 0;
    @(negedge clk);
    checks++;
    if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst} !== {1'b1, 4'd0, 32'h1FC0_0020, 8'd7, 3'd2, 2'b01}) begin
      errors++;
      $display("FAIL i_ar got=%h exp=%h", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
               {1'b1, 4'd0, 32'h1FC0_0020, 8'd7, 3'd2, 2'b01});
    end
    checks++;
    if (i_arready !== 1'b0) begin
      errors++;
      $display("FAIL i_arready_in_ar got=%b exp=0", i_arready);
    end
    tick;
    burst(0, 32'h1FC0_0020, 8);
    checks++;
    if (m_rready !== 1'b0) begin
      errors++;
      $display("FAIL i_idle_after got=%b exp=0", m_rready);
    end
  endtask
  task automatic test_simultaneous;
    d_araddr = 32'h8000_0100; d_arlen = 3; d_arsize = 2;
    i_araddr = 32'h1FC0_0040; i_arlen = 1; i_arsize = 2;
    i_arvalid = 1; d_arvalid = 1;
    @(negedge clk);
    checks++;
    if ({i_arready, d_arready} !== 2'b01) begin
      errors++;
      $display("FAIL tie_d_first got=%b exp=01", {i_arready, d_arready});
    end
    tick;
    d_arvalid = 0;
    @(negedge clk);
    checks++;
    if ({m_arid, m_araddr, m_arlen} !== {4'd1, 32'h8000_0100, 8'd3}) begin
      errors++;
      $display("FAIL d_ar got=%h exp=%h", {m_arid, m_araddr, m_arlen}, {4'd1, 32'h8000_0100, 8'd3});
    end
    tick;
    wait_ar;
    for (int k = 0; k < 4; k++) begin
      beat(1, pat(32'h8000_0100, k), k == 3, 2'b00);
      if (k < 3) begin
        checks++;
        if (i_arready !== 1'b0) begin
          errors++;
          $display("FAIL i_held_off got=%b exp=0", i_arready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({i_arready, d_arready} !== 2'b10) begin
      errors++;
      $display("FAIL i_after_d got=%b exp=10", {i_arready, d_arready});
    end
    tick;
    i_arvalid = 0;
    @(negedge clk);
    checks++;
    if ({m_arid, m_araddr} !== {4'd0, 32'h1FC0_0040}) begin
      errors++;
      $display("FAIL i_ar2 got=%h exp=%h", {m_arid, m_araddr}, {4'd0, 32'h1FC0_0040});
    end
    tick;
    burst(0, 32'h1FC0_0040, 2);
  endtask
  task automatic test_back_to_back;
    bit last_d = 0, exp_d;
    i_araddr = 32'h1FC0_0200; i_arlen = 1;
    d_araddr = 32'h8000_0200; d_arlen = 1;
    i_arvalid = 1; d_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_d = (k == 3) ? !last_d : !last_d;
`else
      exp_d = (k == 3) ? 1'b0 : 1'b1;
`endif
      @(negedge clk);
      checks++;
      if ({i_arready, d_arready} !== {!exp_d, exp_d}) begin
        errors++;
        $display("FAIL b2b_grant%0d got=%b exp=%b", k, {i_arready, d_arready}, {!exp_d, exp_d});
      end
      tick;
      if (exp_d) d_arvalid = 0; else i_arvalid = 0;
      last_d = exp_d;
      @(negedge clk);
      checks++;
      if (m_arid !== (exp_d ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL b2b_arid%0d got=%0d exp=%0d", k, m_arid, exp_d ? 1 : 0);
      end
      tick;
      burst(exp_d, exp_d ? 32'h8000_0200 : 32'h1FC0_0200, 2);
      if (k < 2) begin
        if (exp_d) d_arvalid = 1; else i_arvalid = 1;
      end
    end
  endtask
  task automatic test_backpressure;
    int k = 0;
    bit pushed = 0;
    i_araddr = 32'h1FC0_0080; i_arlen = 7; i_arsize = 2; i_arvalid = 1; m_arready = 0;
    tick;
    i_arvalid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, 32'h1FC0_0080, 8'd7}) begin
        errors++;
        $display("FAIL ar_stable%0d got=%h exp=%h", c, {m_arvalid, m_araddr, m_arlen}, {1'b1, 32'h1FC0_0080, 8'd7});
      end
      tick;
    end
    wait_ar;
    for (int c = 0; c < 40 && k < 8; c++) begin
      i_rready = c[0];
      m_rvalid = 1; m_rdata = pat(32'h1FC0_0080, k); m_rlast = (k == 7);
      if (!pushed) begin
        q.push_back({1'b0, k == 7, pat(32'h1FC0_0080, k)});
        pushed = 1;
      end
      @(negedge clk);
      checks++;
      if (m_rready !== i_rready) begin
        errors++;
        $display("FAIL rready_mirror got=%b exp=%b", m_rready, i_rready);
      end
      if (m_rready) begin
        k++;
        pushed = 0;
      end
      tick;
    end
    m_rvalid = 0; m_rlast = 0; i_rready = 1;
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL bp_beats got=%0d exp=8", k);
    end
  endtask
  task automatic test_error;
    i_araddr = 32'h1FC0_0100; i_arlen = 7; i_arvalid = 1;
    tick;
    i_arvalid = 0;
    wait_ar;
    for (int k = 0; k < 8; k++) begin
      beat(0, pat(32'h1FC0_0100, k), k == 7, k == 2 ? 2'b10 : 2'b00);
      checks++;
      if (rd_err !== (k >= 2)) begin
        errors++;
        $display("FAIL rd_err_beat%0d got=%b exp=%b", k, rd_err, k >= 2);
      end
    end
    repeat (3) tick;
    checks++;
    if (rd_err !== 1'b1) begin
      errors++;
      $display("FAIL rd_err_sticky got=%b exp=1", rd_err);
    end
  endtask
  task automatic test_reset_mid;
    i_araddr = 32'h1FC0_0300; i_arlen = 7; i_arvalid = 1;
    tick;
    i_arvalid = 0;
    wait_ar;
    for (int k = 0; k < 3; k++) beat(0, pat(32'h1FC0_0300, k), 0, 2'b00);
    m_rvalid = 1; m_rdata = pat(32'h1FC0_0300, 3); rst = 1;
    tick;
    rst = 0; m_rvalid = 0;
    checks++;
    if ({m_arvalid, m_rready, rd_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=000", {m_arvalid, m_rready, rd_err});
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_q got=%0d exp=0", q.size());
    end
    i_araddr = 32'h1FC0_0400; i_arlen = 1; i_arvalid = 1;
    @(negedge clk);
    checks++;
    if (i_arready !== 1'b1) begin
      errors++;
      $display("FAIL fresh_grant got=%b exp=1", i_arready);
    end
    tick;
    i_arvalid = 0;
    @(negedge clk);
    checks++;
    if ({m_arid, m_araddr, m_arlen} !== {4'd0, 32'h1FC0_0400, 8'd1}) begin
      errors++;
      $display("FAIL fresh_ar got=%h exp=%h", {m_arid, m_araddr, m_arlen}, {4'd0, 32'h1FC0_0400, 8'd1});
    end
    tick;
    burst(0, 32'h1FC0_0400, 2);
  endtask
  initial begin
    rst = 1;
    {i_araddr, i_arlen, i_arsize, i_arvalid, d_araddr, d_arlen, d_arsize, d_arvalid} = '0;
    {m_arready, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    i_rready = 1; d_rready = 1;
    repeat (2) tick;
    rst = 0;
    test_reset;
    test_i_only;
    test_simultaneous;
    test_back_to_back;
    test_backpressure;
    test_error;
    test_reset_mid;
    repeat (2) tick;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
